// File: rtl/selftest_pkg.sv
// selftest_pkg: shared state encoding, vector type and common gate truth tables
package selftest_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } selftest_state_t;

    typedef logic [1:0] vec_t;

    // Truth tables are indexed by {a,b}.
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter; zero flags that the count is zero after this edge
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    output logic       zero
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load ? value : cnt_q - {7'd0, cnt_q != 8'd0};
        zero  = cnt_d == 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/gate_selftest_seq.sv
// gate_selftest_seq: sweeps a 2-input gate through all vectors and checks y against EXPECT_TT
// Optional per-vector fail_mask output enabled by defining SELFTEST_FAIL_MASK_EN.
module gate_selftest_seq
    import selftest_pkg::*;
#(
    parameter int             SETTLE_CYCLES = 2,
    parameter int             PASSES        = 1,
    parameter logic [3:0]     EXPECT_TT     = TT_NAND,
    parameter int             ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
`ifdef SELFTEST_FAIL_MASK_EN
    output logic [3:0]       fail_mask,
`endif
    output logic [1:0]       vec_idx
);

    selftest_state_t  state_q, state_d;
    vec_t             vec_q, vec_d;
    logic [7:0]       pc_q, pc_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             mis_q, mis_d;
    logic [3:0]       mask_q, mask_d;
    logic             mismatch;
    logic             settle_zero;

    settle_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (state_q == DRIVE),
        .value (8'(SETTLE_CYCLES)),
        .zero  (settle_zero)
    );

    assign mismatch = (state_q == SAMPLE) && (y != EXPECT_TT[vec_q]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        pc_d    = pc_q;
        err_d   = err_q;
        pass_d  = pass_q;
        mis_d   = mis_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = DRIVE;
                vec_d   = 2'd0;
                pc_d    = 8'd0;
                err_d   = '0;
                pass_d  = 1'b0;
                mis_d   = 1'b0;
                mask_d  = 4'd0;
            end
            DRIVE:  state_d = (SETTLE_CYCLES > 0) ? WAIT : SAMPLE;
            WAIT:   state_d = settle_zero ? SAMPLE : WAIT;
            SAMPLE: begin
                err_d          = err_q + ERR_W'(mismatch && (err_q != '1));
                mis_d          = mis_q | mismatch;
                mask_d[vec_q]  = mask_q[vec_q] | mismatch;
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = DRIVE;
                end else if (pc_q != 8'(PASSES - 1)) begin
                    pc_d    = pc_q + 8'd1;
                    vec_d   = 2'd0;
                    state_d = DRIVE;
                end else begin
                    // sticky flag, so a saturated counter cannot hide a failure
                    pass_d  = !(mis_q | mismatch);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            pc_q    <= 8'd0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            mis_q   <= 1'b0;
            mask_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            mis_q   <= mis_d;
            mask_q  <= mask_d;
        end
    end

    assign a         = vec_q[1];
    assign b         = vec_q[0];
    assign vec_idx   = vec_q;
    assign busy      = (state_q == DRIVE) || (state_q == WAIT) || (state_q == SAMPLE);
    assign done      = state_q == DONE;
    assign pass      = pass_q;
    assign err_count = err_q;
`ifdef SELFTEST_FAIL_MASK_EN
    assign fail_mask = mask_q;
`else
    logic unused_mask;
    assign unused_mask = ^mask_q;
`endif

endmodule

// File: doc/gate_selftest_seq.md
Name: gate_selftest_seq

Overview:
- Sequential self-test driver for two-input combinational gates in the design, e.g. `nand_gate`.
- Sits on both sides of the gate under test:
  - upstream: drives the gate's `a`/`b` inputs;
  - downstream: consumes the gate's `y` output.
- Sweeps all four input vectors, waits a settle time, samples `y` and compares it against a parameterised truth table.
- Reports a done pulse, a pass flag and an error count.

Parameters:
- `SETTLE_CYCLES`, 2: wait cycles between driving a vector and sampling `y`. Legal range 0..255.
- `PASSES`, 1: number of full 4-vector sweeps per run. Legal range 1..255.
- `EXPECT_TT`, 4'b0111: expected `y` per vector, indexed by {a,b}. Default is NAND.
- `ERR_W`, 4: width of the error counter.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle run request; ignored while busy
- `a`  out  1  registered drive to gate input a
- `b`  out  1  registered drive to gate input b
- `y`  in  1  gate output under test
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run
- `pass`  out  1  run completed with zero mismatches; held until next start
- `err_count`  out  ERR_W  saturating mismatch count; held until next start
- `vec_idx`  out  2  current vector {a,b}, for debug

Behaviour:
- Reset (`rst`=1 at a rising edge), next cycle:
  - state IDLE;
  - `a`=`b`=0; `busy`=`done`=`pass`=0; `err_count`=0; `vec_idx`=0.
  - Pass counter and settle counter are cleared.
- FSM states: IDLE, DRIVE, WAIT, SAMPLE, DONE.
- IDLE, `start`=1:
  - clear `err_count` and `pass`; `vec_idx`=0; pass counter=0;
  - load {a,b}=00; go to DRIVE; `busy`=1 from the next cycle.
- DRIVE, one cycle:
  - load the settle counter with `SETTLE_CYCLES`;
  - go to WAIT if `SETTLE_CYCLES`>0, else go to SAMPLE.
- WAIT: decrement the counter each cycle; go to SAMPLE when it reaches 0, i.e. exactly `SETTLE_CYCLES` cycles in WAIT.
- SAMPLE, one cycle:
  - compare `y` with `EXPECT_TT[vec_idx]`;
  - on mismatch, `err_count`+1 at the leaving edge, saturating at 2^ERR_W-1.
  - If `vec_idx`<3: `vec_idx`+1, drive {a,b}=the new vector at the leaving edge, go to DRIVE.
  - If `vec_idx`==3 and pass counter<`PASSES`-1: pass counter+1, `vec_idx`=0, {a,b}=00, go to DRIVE.
  - Otherwise go to DONE.
- DONE, one cycle:
  - `done`=1, `busy`=0;
  - `pass`=1 iff no mismatch occurred in the run (based on a sticky mismatch flag, not on `err_count`, so saturation cannot mask the result);
  - {a,b} held at the last vector; next state IDLE.
- Timing:
  - Each vector occupies exactly SETTLE_CYCLES+2 cycles.
  - `a`/`b` are stable throughout DRIVE, WAIT and SAMPLE.
  - With `start` sampled in cycle 0, `done` is high in cycle PASSES*4*(SETTLE_CYCLES+2)+1. Defaults give cycle 17.
- Boundaries and concurrency:
  - `start` while `busy`=1 or in DONE: ignored, with no effect on counters.
  - `start` held high: a new run begins on the first IDLE cycle.
  - `rst` mid-run: aborts immediately to reset values; no `done` pulse.
  - `rst` and `start` together: `rst` wins.
- `y` is assumed combinationally settled within the settle window; no synchroniser (same clock domain).

Optional Feature:
- Macro: `SELFTEST_FAIL_MASK_EN`.
- Defined:
  - adds output port `fail_mask` (out, 4 bits);
  - bit i is set when vector i mismatches in any pass;
  - cleared on `rst` and on accepted `start`; held after DONE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `selftest_pkg`:
  - state enum typedef `selftest_state_t` {IDLE, DRIVE, WAIT, SAMPLE, DONE};
  - `vec_t` (logic [1:0]);
  - truth-table constants `TT_NAND`=4'b0111, `TT_AND`=4'b1000, `TT_OR`=4'b1110, `TT_XOR`=4'b0110.
- Sub-module `settle_timer`:
  - loadable down-counter with `load`, `value[7:0]` and `zero` outputs;
  - instantiated once, used by DRIVE/WAIT.

Test Plan:
1. Ideal `nand_gate` attached, defaults, `start` in cycle 0 → {a,b} = 00, 01, 10, 11, each held 4 cycles; `done` in cycle 17; `pass`=1; `err_count`=0; `fail_mask`=0000.
2. `y` stuck at 1, defaults → vector 11 mismatches; `err_count`=1, `pass`=0, `fail_mask`=1000; `done` in cycle 17.
3. `y` stuck at 0, `PASSES`=2 → `err_count`=6, `fail_mask`=0111; `done` in cycle 33.
4. `y` stuck at 0, `PASSES`=8, `ERR_W`=4 → 24 mismatches saturate at `err_count`=15; `pass`=0.
5. `start` re-pulsed in cycle 5 → ignored, `done` still in cycle 17. Then `rst` in cycle 7 of a new run → next cycle all outputs reset, no `done` pulse; a subsequent `start` runs cleanly.
6. `SETTLE_CYCLES`=0, ideal gate → each vector held 2 cycles; `done` in cycle 9; `pass`=1.
